// File: rtl/rsa_operand_loader.sv
// rsa_operand_loader: parses a serial byte frame (mp_count, e_idx, x-bar, m-bar, e, n).
// x-bar and m-bar are packed into DBITS words and written to memory, least-significant
// word at the base address; e and n are presented as N-bit outputs.
// Optional build macro: RSA_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module rsa_operand_loader #(
    parameter int unsigned N         = 64,
    parameter int unsigned DBITS     = 32,
    parameter int unsigned ABITS     = 8,
    parameter int unsigned NLOG2     = 6,
    parameter int unsigned XBAR_BASE = 0,
    parameter int unsigned MBAR_BASE = N / DBITS
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx_valid,
    input  logic [7:0]       i_rx_byte,
    output logic             o_rx_ready,
    output logic [NLOG2-1:0] o_tx_mp_count,
    output logic [NLOG2-1:0] o_tx_e_idx,
    output logic [N-1:0]     o_tx_e,
    output logic [N-1:0]     o_tx_n,
    output logic             o_tx_valid,
    input  logic             i_tx_ready,
    output logic             o_wr_en,
    output logic [ABITS-1:0] o_wr_addr,
    output logic [DBITS-1:0] o_wr_data,
    output logic             o_frame_err
);

    localparam int unsigned NBYTES = N / 8;
    localparam int unsigned BPW    = DBITS / 8;
    localparam int unsigned NWORDS = N / DBITS;
    localparam int unsigned CW     = $clog2(NBYTES + 1);
    localparam int unsigned WBW    = $clog2(BPW + 1);
    localparam int unsigned KW     = $clog2(NWORDS + 1);

`ifdef RSA_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_MP, S_EIDX, S_XBAR, S_MBAR, S_E, S_N, S_CSUM, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_MP, S_EIDX, S_XBAR, S_MBAR, S_E, S_N, S_DONE} state_t;
`endif

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;      // bytes accepted in the current state
    logic [WBW-1:0]   r_wb;       // bytes in the current memory word
    logic [KW-1:0]    r_wk;       // words completed in the current operand
    logic [DBITS-1:0] r_acc;
    logic [N-1:0]     r_sh;
    logic [NLOG2-1:0] r_mp, r_eidx;
    logic [N-1:0]     r_tx_e, r_tx_n;
    logic             r_wr_en;
    logic [ABITS-1:0] r_wr_addr;
    logic [DBITS-1:0] r_wr_data;

    logic             w_acc;
    logic             w_last_byte;
    logic             w_word_done;
    logic [DBITS-1:0] w_acc_next;
    logic [N-1:0]     w_sh_next;
    logic [ABITS-1:0] w_base;
    logic [ABITS-1:0] w_addr;

    assign w_acc       = i_rx_valid && o_rx_ready;
    assign w_last_byte = (r_cnt == CW'(NBYTES - 1));
    assign w_word_done = (r_wb == WBW'(BPW - 1));
    assign w_acc_next  = (r_acc << 8) | DBITS'(i_rx_byte);
    assign w_sh_next   = (r_sh << 8) | N'(i_rx_byte);
    assign w_base      = (r_state == S_XBAR) ? ABITS'(XBAR_BASE) : ABITS'(MBAR_BASE);
    // First-received word is the most significant, so it lands at the top address.
    assign w_addr      = w_base + ABITS'(NWORDS - 1) - ABITS'(r_wk);

`ifdef RSA_LOADER_CHECKSUM_EN
    logic [7:0] r_csum;
    logic       r_frame_err;
    logic       w_csum_ok;

    assign w_csum_ok   = (r_csum == i_rx_byte);
    assign o_frame_err = r_frame_err;

    // Running XOR of the frame; checksum byte compared in S_CSUM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_csum      <= 8'h00;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_acc && (r_state == S_CSUM) && !w_csum_ok;
            if (w_acc) begin
                r_csum <= (r_state == S_MP) ? i_rx_byte : (r_csum ^ i_rx_byte);
            end
        end
    end
`else
    assign o_frame_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_MP;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_MP:   if (w_acc) w_next = S_EIDX;
            S_EIDX: if (w_acc) w_next = S_XBAR;
            S_XBAR: if (w_acc && w_last_byte) w_next = S_MBAR;
            S_MBAR: if (w_acc && w_last_byte) w_next = S_E;
            S_E:    if (w_acc && w_last_byte) w_next = S_N;
`ifdef RSA_LOADER_CHECKSUM_EN
            S_N:    if (w_acc && w_last_byte) w_next = S_CSUM;
            S_CSUM: if (w_acc) w_next = w_csum_ok ? S_DONE : S_MP;
`else
            S_N:    if (w_acc && w_last_byte) w_next = S_DONE;
`endif
            S_DONE: if (i_tx_ready) w_next = S_MP;
            default: w_next = S_MP;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        o_rx_ready = (r_state != S_DONE);
        o_tx_valid = (r_state == S_DONE);
    end

    // Datapath: header capture, word packing with memory writes, e/n shift registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_wb      <= '0;
            r_wk      <= '0;
            r_acc     <= '0;
            r_sh      <= '0;
            r_mp      <= '0;
            r_eidx    <= '0;
            r_tx_e    <= '0;
            r_tx_n    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_acc) begin
                r_cnt <= r_cnt + CW'(1);
                unique case (r_state)
                    S_MP:   r_mp   <= NLOG2'(i_rx_byte);
                    S_EIDX: r_eidx <= NLOG2'(i_rx_byte);
                    S_XBAR, S_MBAR: begin
                        r_acc <= w_acc_next;
                        if (w_word_done) begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= w_acc_next;
                            r_wr_addr <= w_addr;
                            r_wb      <= '0;
                            r_wk      <= r_wk + KW'(1);
                        end else begin
                            r_wb <= r_wb + WBW'(1);
                        end
                    end
                    S_E: begin
                        r_sh <= w_sh_next;
                        if (w_last_byte) r_tx_e <= w_sh_next;
                    end
                    S_N: begin
                        r_sh <= w_sh_next;
                        if (w_last_byte) r_tx_n <= w_sh_next;
                    end
                    default: ;
                endcase
            end
            // Counters restart at every state boundary.
            if (w_next != r_state) begin
                r_cnt <= '0;
                r_wb  <= '0;
                r_wk  <= '0;
            end
        end
    end

    assign o_tx_mp_count = r_mp;
    assign o_tx_e_idx    = r_eidx;
    assign o_tx_e        = r_tx_e;
    assign o_tx_n        = r_tx_n;
    assign o_wr_en       = r_wr_en;
    assign o_wr_addr     = r_wr_addr;
    assign o_wr_data     = r_wr_data;

endmodule

// File: tb/tb_rsa_operand_loader.sv
// Directed bench for rsa_operand_loader (N=64, DBITS=32, defaults).
// Covers back-to-back and throttled frames, consumer back-pressure, mid-frame reset,
// and the checksum variant when RSA_LOADER_CHECKSUM_EN is defined.
module tb_rsa_operand_loader;

    localparam int N     = 64;
    localparam int DBITS = 32;
    localparam int ABITS = 8;
    localparam int NLOG2 = 6;
`ifdef RSA_LOADER_CHECKSUM_EN
    localparam int FL = 35;
`else
    localparam int FL = 34;
`endif

    logic             i_clk;
    logic             i_rst_n;
    logic             i_rx_valid;
    logic [7:0]       i_rx_byte;
    logic             o_rx_ready;
    logic [NLOG2-1:0] o_tx_mp_count;
    logic [NLOG2-1:0] o_tx_e_idx;
    logic [N-1:0]     o_tx_e;
    logic [N-1:0]     o_tx_n;
    logic             o_tx_valid;
    logic             i_tx_ready;
    logic             o_wr_en;
    logic [ABITS-1:0] o_wr_addr;
    logic [DBITS-1:0] o_wr_data;
    logic             o_frame_err;

    rsa_operand_loader #(
        .N        (N),
        .DBITS    (DBITS),
        .ABITS    (ABITS),
        .NLOG2    (NLOG2),
        .XBAR_BASE(0),
        .MBAR_BASE(2)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_rx_valid   (i_rx_valid),
        .i_rx_byte    (i_rx_byte),
        .o_rx_ready   (o_rx_ready),
        .o_tx_mp_count(o_tx_mp_count),
        .o_tx_e_idx   (o_tx_e_idx),
        .o_tx_e       (o_tx_e),
        .o_tx_n       (o_tx_n),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (i_tx_ready),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_frame_err  (o_frame_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          wr_cnt = 0;
    int          tv_cnt = 0;
    int          fe_cnt = 0;
    logic [31:0] mem [0:255];
    logic [7:0]  fb  [0:FL-1];

    // Memory and event monitor, sampled on the falling edge.
    always @(negedge i_clk) begin
        if (o_wr_en) begin
            mem[o_wr_addr] = o_wr_data;
            wr_cnt = wr_cnt + 1;
        end
        if (o_tx_valid) tv_cnt = tv_cnt + 1;
        if (o_frame_err) fe_cnt = fe_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic build_frame(input logic [7:0] mp, input logic [7:0] ei,
                               input logic [63:0] x, input logic [63:0] m,
                               input logic [63:0] e, input logic [63:0] n);
        logic [7:0] cs;
        fb[0] = mp;
        fb[1] = ei;
        for (int i = 0; i < 8; i++) begin
            fb[2 + i]  = x[63 - 8*i -: 8];
            fb[10 + i] = m[63 - 8*i -: 8];
            fb[18 + i] = e[63 - 8*i -: 8];
            fb[26 + i] = n[63 - 8*i -: 8];
        end
        cs = 8'h00;
        for (int i = 0; i < 34; i++) cs = cs ^ fb[i];
`ifdef RSA_LOADER_CHECKSUM_EN
        fb[34] = cs;
`endif
    endtask

    // Called at a falling edge; returns at the falling edge after the byte is taken.
    task automatic send(input logic [7:0] b);
        int guard;
        guard = 0;
        i_rx_valid = 1'b1;
        i_rx_byte  = b;
        while (!o_rx_ready && guard < 40) begin
            @(negedge i_clk);
            guard++;
        end
        if (guard >= 40) begin
            n_cmp++;
            n_mis++;
            $error("FAIL rx_timeout: observed rx_ready=0 expected rx_ready=1 within 40 cycles");
        end
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input int gap, input int count);
        for (int i = 0; i < count; i++) begin
            send(fb[i]);
            if (i < count - 1) repeat (gap) @(negedge i_clk);
        end
    endtask

    // Checks for the reference frame, entered in the first S_DONE cycle.
    task automatic check_f1(input string tag, input int base_wr, input int base_tv);
        chk({tag, "_tx_valid"}, 64'(o_tx_valid), 64'd1);
        chk({tag, "_rx_ready_done"}, 64'(o_rx_ready), 64'd0);
        chk({tag, "_mp"}, 64'(o_tx_mp_count), 64'd5);
        chk({tag, "_eidx"}, 64'(o_tx_e_idx), 64'd3);
        chk({tag, "_tx_e"}, o_tx_e, 64'h0000_0000_0001_0001);
        chk({tag, "_tx_n"}, o_tx_n, 64'h0000_0000_C000_0001);
        @(negedge i_clk);
        chk({tag, "_tx_valid_fall"}, 64'(o_tx_valid), 64'd0);
        chk({tag, "_rx_ready_back"}, 64'(o_rx_ready), 64'd1);
        chk({tag, "_tv_cycles"}, 64'(tv_cnt - base_tv), 64'd1);
        chk({tag, "_wr_count"}, 64'(wr_cnt - base_wr), 64'd4);
        chk({tag, "_mem1"}, 64'(mem[1]), 64'h0011_2233);
        chk({tag, "_mem0"}, 64'(mem[0]), 64'h4455_6677);
        chk({tag, "_mem3"}, 64'(mem[3]), 64'h8899_AABB);
        chk({tag, "_mem2"}, 64'(mem[2]), 64'hCCDD_EEFF);
        chk({tag, "_wr_addr_hold"}, 64'(o_wr_addr), 64'd2);
        chk({tag, "_wr_data_hold"}, 64'(o_wr_data), 64'hCCDD_EEFF);
    endtask

    task automatic build_f1();
        build_frame(8'h05, 8'h03, 64'h0011_2233_4455_6677, 64'h8899_AABB_CCDD_EEFF,
                    64'h0000_0000_0001_0001, 64'h0000_0000_C000_0001);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish before 200us");
        $fatal(1);
    end

    initial begin
        int base_wr;
        int base_tv;
        int base_fe;

        i_rst_n    = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_byte  = 8'h00;
        i_tx_ready = 1'b1;
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_tx_valid", 64'(o_tx_valid), 64'd0);
        chk("rst_rx_ready", 64'(o_rx_ready), 64'd1);
        chk("rst_wr_en", 64'(o_wr_en), 64'd0);
        chk("rst_frame_err", 64'(o_frame_err), 64'd0);
        chk("rst_tx_e", o_tx_e, 64'd0);
        chk("rst_wr_addr", 64'(o_wr_addr), 64'd0);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        // Back-to-back frame, consumer always ready.
        build_f1();
        base_wr = wr_cnt;
        base_tv = tv_cnt;
        send_frame(0, FL);
        check_f1("b2b", base_wr, base_tv);

        // Same frame with rx_valid on every other cycle.
        base_wr = wr_cnt;
        base_tv = tv_cnt;
        send_frame(1, FL);
        check_f1("gap", base_wr, base_tv);

        // Consumer stalls 10 cycles; next frame's first byte waits upstream.
        i_tx_ready = 1'b0;
        base_wr = wr_cnt;
        base_tv = tv_cnt;
        send_frame(0, FL);
        build_frame(8'hEA, 8'h7F, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                    64'h0000_0000_0000_0003, 64'hFFFF_FFFF_FFFF_FFC5);
        i_rx_valid = 1'b1;
        i_rx_byte  = fb[0];
        for (int i = 0; i < 10; i++) begin
            chk("stall_tx_valid", 64'(o_tx_valid), 64'd1);
            chk("stall_rx_ready", 64'(o_rx_ready), 64'd0);
            if (i == 9) begin
                chk("stall_mp_hold", 64'(o_tx_mp_count), 64'd5);
                i_tx_ready = 1'b1;
            end
            @(negedge i_clk);
        end
        chk("stall_release_tx_valid", 64'(o_tx_valid), 64'd0);
        chk("stall_release_rx_ready", 64'(o_rx_ready), 64'd1);
        send_frame(0, FL);
        chk("f2_tx_valid", 64'(o_tx_valid), 64'd1);
        chk("f2_mp_trunc", 64'(o_tx_mp_count), 64'h2A);
        chk("f2_eidx_trunc", 64'(o_tx_e_idx), 64'h3F);
        chk("f2_tx_e", o_tx_e, 64'h0000_0000_0000_0003);
        chk("f2_tx_n", o_tx_n, 64'hFFFF_FFFF_FFFF_FFC5);
        @(negedge i_clk);
        chk("f2_tv_cycles", 64'(tv_cnt - base_tv), 64'd11);
        chk("f2_wr_count", 64'(wr_cnt - base_wr), 64'd8);
        chk("f2_mem1", 64'(mem[1]), 64'h0123_4567);
        chk("f2_mem0", 64'(mem[0]), 64'h89AB_CDEF);
        chk("f2_mem3", 64'(mem[3]), 64'hFEDC_BA98);
        chk("f2_mem2", 64'(mem[2]), 64'h7654_3210);

        // Reset after 9 bytes of a frame, then a complete different frame.
        build_frame(8'h01, 8'h02, 64'hDEAD_BEEF_CAFE_F00D, 64'h1111_2222_3333_4444,
                    64'h5555_6666_7777_8888, 64'h9999_AAAA_BBBB_CCCC);
        send_frame(0, 9);
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_tx_e", o_tx_e, 64'd0);
        chk("mid_rst_tx_n", o_tx_n, 64'd0);
        chk("mid_rst_mp", 64'(o_tx_mp_count), 64'd0);
        chk("mid_rst_eidx", 64'(o_tx_e_idx), 64'd0);
        chk("mid_rst_wr_data", 64'(o_wr_data), 64'd0);
        chk("mid_rst_wr_addr", 64'(o_wr_addr), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        base_wr = wr_cnt;
        base_tv = tv_cnt;
        build_frame(8'h21, 8'h00, 64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0,
                    64'h0000_0000_0000_0011, 64'h8000_0000_0000_0001);
        send_frame(0, FL);
        chk("f4_tx_valid", 64'(o_tx_valid), 64'd1);
        chk("f4_mp", 64'(o_tx_mp_count), 64'h21);
        chk("f4_eidx", 64'(o_tx_e_idx), 64'h00);
        chk("f4_tx_e", o_tx_e, 64'h0000_0000_0000_0011);
        chk("f4_tx_n", o_tx_n, 64'h8000_0000_0000_0001);
        @(negedge i_clk);
        chk("f4_wr_count", 64'(wr_cnt - base_wr), 64'd4);
        chk("f4_mem1", 64'(mem[1]), 64'h0F1E_2D3C);
        chk("f4_mem0", 64'(mem[0]), 64'h4B5A_6978);
        chk("f4_mem3", 64'(mem[3]), 64'h8796_A5B4);
        chk("f4_mem2", 64'(mem[2]), 64'hC3D2_E1F0);

`ifdef RSA_LOADER_CHECKSUM_EN
        // Corrupted checksum byte, then a good frame.
        build_f1();
        fb[FL-1] = fb[FL-1] ^ 8'h01;
        base_tv = tv_cnt;
        base_fe = fe_cnt;
        send_frame(0, FL);
        @(negedge i_clk);
        chk("csum_bad_frame_err", 64'(fe_cnt - base_fe), 64'd1);
        chk("csum_bad_no_valid", 64'(tv_cnt - base_tv), 64'd0);
        chk("csum_bad_rx_ready", 64'(o_rx_ready), 64'd1);
        base_wr = wr_cnt;
        base_tv = tv_cnt;
        build_f1();
        send_frame(0, FL);
        check_f1("csum_good", base_wr, base_tv);
        chk("csum_good_no_err", 64'(fe_cnt - base_fe), 64'd1);
`else
        base_fe = 0;
        chk("no_frame_err", 64'(fe_cnt), 64'(base_fe));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/rsa_operand_loader.md
RSA_OPERAND_LOADER -- requirements
Module: rsa_operand_loader

Interface
REQ-001 Parameter N, default 64: operand width in bits; SHALL be a multiple of DBITS.
REQ-002 Parameter DBITS, default 32: memory word width; SHALL be a multiple of 8.
REQ-003 Parameter ABITS, default 8: memory address width.
REQ-004 Parameter NLOG2, default 6: width of the mp_count and e_idx outputs.
REQ-005 Parameters XBAR_BASE (default 0) and MBAR_BASE (default N/DBITS): memory base address of x-bar and m-bar respectively.
REQ-006 clk  in  1  sole clock; all state changes on the rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 rx_valid  in  1  rx_byte is valid this cycle.
REQ-009 rx_byte  in  8  serial input byte.
REQ-010 rx_ready  out  1  loader accepts a byte; a transfer occurs when rx_valid && rx_ready.
REQ-011 tx_mp_count  out  NLOG2  header byte 0, low NLOG2 bits.
REQ-012 tx_e_idx  out  NLOG2  header byte 1, low NLOG2 bits.
REQ-013 tx_e  out  N  exponent operand.
REQ-014 tx_n  out  N  modulus operand.
REQ-015 tx_valid  out  1  frame complete; all tx_* outputs and memory contents are valid.
REQ-016 tx_ready  in  1  consumer accepts the frame.
REQ-017 wr_en, wr_addr[ABITS], wr_data[DBITS]  out  memory write port; one word per wr_en cycle.
REQ-018 frame_err  out  1  one-cycle pulse on a checksum failure (CHECKSUM build only; otherwise tied 0).

Function
REQ-019 Frame layout, in order: mp_count byte, e_idx byte, x-bar, m-bar, e, n; every operand is N/8 bytes, most-significant byte first.
REQ-020 FSM states: S_MP, S_EIDX, S_XBAR, S_MBAR, S_E, S_N, S_CSUM (CHECKSUM build only), S_DONE.
REQ-021 Transitions: S_MP→S_EIDX→S_XBAR on one accepted byte each; each operand state advances after exactly N/8 accepted bytes; S_N→S_CSUM (or S_DONE); S_CSUM→S_DONE on a match, or →S_MP with a frame_err pulse on a mismatch.
REQ-022 A byte counter SHALL reset to 0 on every state change; there SHALL be no off-by-one between operand boundaries.
REQ-023 In S_XBAR and S_MBAR, bytes SHALL shift into a DBITS accumulator; each time DBITS/8 bytes are complete, wr_en SHALL pulse for one cycle, in the cycle after the completing byte is accepted.
REQ-024 The address of the k-th word of an operand (k = 0 first received) SHALL be base + (N/DBITS − 1 − k), so the least-significant word is at base.
REQ-025 wr_en SHALL be 0 in all cycles other than those defined in REQ-023; wr_addr and wr_data hold their last values.
REQ-026 In S_E and S_N, bytes SHALL shift into an N-bit register: reg ← (reg << 8) | rx_byte; tx_e and tx_n update only on the final byte of their operand.
REQ-027 rx_ready SHALL be 1 in every state except S_DONE.
REQ-028 S_DONE: tx_valid = 1, held until a cycle with tx_ready = 1; that cycle returns the FSM to S_MP and tx_valid falls on the next edge.
REQ-029 tx_valid and tx_ready both high in the first S_DONE cycle: single-cycle tx_valid; the next frame's byte is accepted on the following cycle.
REQ-030 rx_valid while rx_ready = 0: byte not consumed; upstream holds it.
REQ-031 tx_mp_count, tx_e_idx, tx_e and tx_n SHALL remain stable from S_DONE until overwritten by the next frame.

Reset
REQ-032 rst_n low SHALL immediately force: state = S_MP, all counters and accumulators = 0, tx_valid = 0, wr_en = 0, frame_err = 0, tx_e = tx_n = 0, tx_mp_count = tx_e_idx = 0, wr_addr = 0, wr_data = 0.
REQ-033 Reset mid-frame SHALL discard the partial frame; the first byte accepted after reset release is treated as mp_count.

Configuration
REQ-034 Macro RSA_LOADER_CHECKSUM_EN defined: the frame carries one trailing byte equal to the XOR of all preceding frame bytes; a mismatch pulses frame_err for one cycle, suppresses tx_valid, and returns the FSM to S_MP.
REQ-035 Macro undefined: no S_CSUM state, no checksum logic, frame_err tied 0, and S_N goes directly to S_DONE.

Verification (N=64, DBITS=32, defaults)
REQ-036 Frame 05,03, xbar 0011223344556677, mbar 8899AABBCCDDEEFF, e 0000000000010001, n 00000000C0000001, back-to-back, tx_ready=1 -> writes [1]=00112233, [0]=44556677, [3]=8899AABB, [2]=CCDDEEFF; tx_e=10001, tx_n=C0000001, mp=5, e_idx=3; tx_valid for 1 cycle.
REQ-037 Same frame with rx_valid toggling every other cycle -> identical writes and outputs; no byte lost or duplicated.
REQ-038 tx_ready=0 for 10 cycles after frame completion -> tx_valid and rx_ready=0 held for 10 cycles; a byte presented meanwhile is not consumed; it is accepted after tx_ready rises.
REQ-039 rst_n pulsed low after 9 bytes, then a full frame -> only the second frame's values appear; wr_en count = 4.
REQ-040 CHECKSUM build: correct XOR byte -> tx_valid; corrupted checksum byte -> frame_err pulse, no tx_valid, next frame loads correctly.
